// File: rtl/prio_req_capture.sv
// ============================================================================
// Module      : prio_req_capture
// Description : Synchronises four asynchronous request lines, keeps sticky
//               pending bits for the external priority encoder and offers the
//               winning code on a valid/ack handshake.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prio_req_capture #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          EDGE_MODE   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:1] req_in,
   input  logic [4:1] mask,
   output logic [4:1] r_out,
   input  logic [2:0] code_in,
   output logic       svc_valid,
   output logic [2:0] svc_code,
   input  logic       svc_ack,
   output logic [4:1] overflow,
   input  logic       clr_ovf
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   logic [4:1] r_sync [SYNC_STAGES];
   logic [4:1] r_dly;
   logic [4:1] r_pending;
   logic [4:1] r_overflow;
   logic       r_valid;
   logic [2:0] r_code;
   state_t     r_state;

   logic [4:1] w_sync;
   logic [4:1] w_rise;
   logic [4:1] w_clr;
   logic [4:1] w_pend_nxt;
   logic [4:1] w_ovf_nxt;
   logic       w_code_ok;

   // Per-bit synchroniser chain; stage 0 samples the raw asynchronous inputs.
   genvar k;
   generate
      for (k = 0; k < SYNC_STAGES; k++) begin : g_sync_stage
         if (k == 0) begin : g_first
            always_ff @(posedge clk or posedge reset) begin
               if (reset) r_sync[k] <= '0;
               else       r_sync[k] <= req_in;
            end
         end else begin : g_rest
            always_ff @(posedge clk or posedge reset) begin
               if (reset) r_sync[k] <= '0;
               else       r_sync[k] <= r_sync[k-1];
            end
         end
      end
   endgenerate

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_rise = w_sync & ~r_dly;

   // The serviced bit is cleared on the accepting edge only.
   always_comb begin
      w_clr = '0;
      if (r_state == ST_OFFER && svc_ack) begin
         for (int i = 1; i <= 4; i++) begin
            w_clr[i] = (r_code == 3'(i));
         end
      end
   end

   generate
      if (EDGE_MODE) begin : g_edge
         // A fresh edge beats a same-cycle clear so the new event is not lost.
         assign w_pend_nxt = (r_pending & ~w_clr) | (w_rise & ~mask);
         assign w_ovf_nxt  = clr_ovf ? 4'b0000
                           : (r_overflow | (w_rise & ~mask & r_pending & ~w_clr));
      end else begin : g_level
         assign w_pend_nxt = w_sync & ~mask & ~w_clr;
         assign w_ovf_nxt  = 4'b0000;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dly      <= '0;
         r_pending  <= '0;
         r_overflow <= '0;
      end else begin
         r_dly      <= w_sync;
         r_pending  <= w_pend_nxt;
         r_overflow <= w_ovf_nxt;
      end
   end

   // Codes 5..7 cannot come from a healthy encoder and are treated as none.
   assign w_code_ok = (code_in != 3'd0) && (code_in <= 3'd4);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_code  <= 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_code_ok) begin
                  r_code  <= code_in;
                  r_valid <= 1'b1;
                  r_state <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (svc_ack) begin
                  r_valid <= 1'b0;
                  r_state <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign r_out     = r_pending & ~mask;
   assign svc_valid = r_valid;
   assign svc_code  = r_code;
   assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_prio_req_capture.sv
// ============================================================================
// Module      : tb_prio_req_capture
// Description : Directed scenarios plus a randomized run against a reference
//               model for prio_req_capture.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prio_req_capture;

   localparam int unsigned SS = 2;
   localparam bit          EM = 1'b1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:1] req_in = '0;
   logic [4:1] mask = '0;
   logic [4:1] r_out;
   logic [2:0] code_in;
   logic       svc_valid;
   logic [2:0] svc_code;
   logic       svc_ack = 1'b0;
   logic [4:1] overflow;
   logic       clr_ovf = 1'b0;
   logic       ovr_en = 1'b0;
   logic [2:0] ovr_code = '0;

   int checks = 0;
   int failures = 0;

   // Reference-model state
   logic [4:1] hist [0:8];
   logic [4:1] m_p;
   logic [4:1] m_ovf;
   bit         m_valid;
   int         m_code;
   int         m_gap;

   always #5 clk = ~clk;

   // Priority encoder standing in for the downstream block.
   function automatic logic [2:0] enc(input logic [4:1] v);
      if (v[4])      return 3'd4;
      else if (v[3]) return 3'd3;
      else if (v[2]) return 3'd2;
      else if (v[1]) return 3'd1;
      else           return 3'd0;
   endfunction

   assign code_in = ovr_en ? ovr_code : enc(r_out);

   prio_req_capture #(.SYNC_STAGES(SS), .EDGE_MODE(EM)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_in    (req_in),
      .mask      (mask),
      .r_out     (r_out),
      .code_in   (code_in),
      .svc_valid (svc_valid),
      .svc_code  (svc_code),
      .svc_ack   (svc_ack),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      svc_ack = 1'b0;
      clr_ovf = 1'b0;
      mask    = '0;
      ovr_en  = 1'b0;
      reset   = 1'b1;
      tick();
      tick();
      reset   = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      req_in = 4'b1111;
      reset  = 1'b1;
      #1;
      checks++; if (r_out !== 4'b0000) begin failures++; $display("FAIL reset_async r_out got=%b want=0000", r_out); end
      checks++; if (svc_valid !== 1'b0) begin failures++; $display("FAIL reset_async svc_valid got=%b want=0", svc_valid); end
      tick();
      tick();
      checks++; if (svc_code !== 3'd0) begin failures++; $display("FAIL reset_held svc_code got=%0d want=0", svc_code); end
      checks++; if (overflow !== 4'b0000) begin failures++; $display("FAIL reset_held overflow got=%b want=0000", overflow); end
      reset = 1'b0;
      tick();
      tick();
      checks++; if (r_out !== 4'b0000) begin failures++; $display("FAIL reset_latency r_out got=%b want=0000", r_out); end
      tick();
      checks++; if (r_out !== 4'b1111) begin failures++; $display("FAIL reset_capture r_out got=%b want=1111", r_out); end
      tick();
      checks++; if (svc_valid !== 1'b1 || svc_code !== 3'd4) begin failures++; $display("FAIL reset_offer valid/code got=%b/%0d want=1/4", svc_valid, svc_code); end
   endtask

   task automatic test_reset_mid;
      req_in = 4'b0000;
      do_reset();
      req_in = 4'b0100;
      repeat (4) tick();
      checks++; if (svc_valid !== 1'b1 || svc_code !== 3'd3) begin failures++; $display("FAIL midrst_offer valid/code got=%b/%0d want=1/3", svc_valid, svc_code); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (svc_valid !== 1'b0 || r_out !== 4'b0000) begin failures++; $display("FAIL midrst_clear valid/r_out got=%b/%b want=0/0000", svc_valid, r_out); end
      reset = 1'b0;
      repeat (3) tick();
      checks++; if (r_out !== 4'b0100) begin failures++; $display("FAIL midrst_recapture r_out got=%b want=0100", r_out); end
      tick();
      checks++; if (svc_valid !== 1'b1 || svc_code !== 3'd3) begin failures++; $display("FAIL midrst_reoffer valid/code got=%b/%0d want=1/3", svc_valid, svc_code); end
   endtask

   task automatic test_single;
      req_in = 4'b0000;
      do_reset();
      req_in = 4'b0010;
      tick();
      tick();
      checks++; if (r_out !== 4'b0000) begin failures++; $display("FAIL single_early r_out got=%b want=0000", r_out); end
      tick();
      checks++; if (r_out !== 4'b0010 || svc_valid !== 1'b0) begin failures++; $display("FAIL single_rout r_out/valid got=%b/%b want=0010/0", r_out, svc_valid); end
      tick();
      checks++; if (svc_valid !== 1'b1 || svc_code !== 3'd2) begin failures++; $display("FAIL single_offer valid/code got=%b/%0d want=1/2", svc_valid, svc_code); end
      tick();
      req_in = 4'b0000;
      svc_ack = 1'b1;
      tick();
      svc_ack = 1'b0;
      checks++; if (svc_valid !== 1'b0 || r_out !== 4'b0000) begin failures++; $display("FAIL single_ack valid/r_out got=%b/%b want=0/0000", svc_valid, r_out); end
      repeat (4) tick();
      checks++; if (svc_valid !== 1'b0) begin failures++; $display("FAIL single_idle svc_valid got=%b want=0", svc_valid); end
   endtask

   task automatic test_priority;
      logic [2:0] exp_codes [3];
      exp_codes[0] = 3'd4;
      exp_codes[1] = 3'd2;
      exp_codes[2] = 3'd1;
      req_in = 4'b0000;
      do_reset();
      req_in = 4'b1011;
      repeat (4) tick();
      for (int n = 0; n < 3; n++) begin
         checks++; if (svc_valid !== 1'b1 || svc_code !== exp_codes[n]) begin failures++; $display("FAIL prio_offer%0d valid/code got=%b/%0d want=1/%0d", n, svc_valid, svc_code, exp_codes[n]); end
         svc_ack = 1'b1;
         tick();
         svc_ack = 1'b0;
         checks++; if (svc_valid !== 1'b0) begin failures++; $display("FAIL prio_clear%0d svc_valid got=%b want=0", n, svc_valid); end
         tick();
         checks++; if (svc_valid !== 1'b0) begin failures++; $display("FAIL prio_idle%0d svc_valid got=%b want=0", n, svc_valid); end
         tick();
      end
      checks++; if (svc_valid !== 1'b0 || r_out !== 4'b0000) begin failures++; $display("FAIL prio_done valid/r_out got=%b/%b want=0/0000", svc_valid, r_out); end
   endtask

   task automatic test_collision;
      req_in = 4'b0000;
      do_reset();
      req_in = 4'b1000;
      repeat (4) tick();
      req_in = 4'b0000;
      repeat (3) tick();
      req_in = 4'b1000;
      tick();
      tick();
      svc_ack = 1'b1;
      tick();
      svc_ack = 1'b0;
      checks++; if (svc_valid !== 1'b0 || r_out !== 4'b1000) begin failures++; $display("FAIL collide_keep valid/r_out got=%b/%b want=0/1000", svc_valid, r_out); end
      checks++; if (overflow !== 4'b0000) begin failures++; $display("FAIL collide_ovf overflow got=%b want=0000", overflow); end
      tick();
      tick();
      checks++; if (svc_valid !== 1'b1 || svc_code !== 3'd4) begin failures++; $display("FAIL collide_reoffer valid/code got=%b/%0d want=1/4", svc_valid, svc_code); end
   endtask

   task automatic test_overflow_mask;
      req_in = 4'b0000;
      do_reset();
      req_in = 4'b0100;
      repeat (4) tick();
      req_in = 4'b0000;
      repeat (3) tick();
      req_in = 4'b0100;
      tick();
      tick();
      checks++; if (overflow !== 4'b0000) begin failures++; $display("FAIL ovf_early overflow got=%b want=0000", overflow); end
      tick();
      checks++; if (overflow !== 4'b0100) begin failures++; $display("FAIL ovf_set overflow got=%b want=0100", overflow); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checks++; if (overflow !== 4'b0000) begin failures++; $display("FAIL ovf_clear overflow got=%b want=0000", overflow); end
      svc_ack = 1'b1;
      tick();
      svc_ack = 1'b0;
      mask   = 4'b0001;
      req_in = 4'b0101;
      repeat (5) tick();
      checks++; if (r_out !== 4'b0000 || svc_valid !== 1'b0) begin failures++; $display("FAIL mask_block r_out/valid got=%b/%b want=0000/0", r_out, svc_valid); end
      mask = 4'b0000;
      tick();
      checks++; if (r_out !== 4'b0000) begin failures++; $display("FAIL mask_nocapture r_out got=%b want=0000", r_out); end
   endtask

   task automatic test_stability;
      req_in = 4'b0000;
      do_reset();
      req_in = 4'b0001;
      repeat (4) tick();
      req_in = 4'b1001;
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++; if (svc_valid !== 1'b1 || svc_code !== 3'd1) begin failures++; $display("FAIL stable_hold%0d valid/code got=%b/%0d want=1/1", n, svc_valid, svc_code); end
      end
      checks++; if (r_out !== 4'b1001) begin failures++; $display("FAIL stable_rout r_out got=%b want=1001", r_out); end
      svc_ack = 1'b1;
      tick();
      svc_ack = 1'b0;
      tick();
      tick();
      checks++; if (svc_valid !== 1'b1 || svc_code !== 3'd4) begin failures++; $display("FAIL stable_next valid/code got=%b/%0d want=1/4", svc_valid, svc_code); end
   endtask

   task automatic test_bad_code;
      req_in = 4'b0000;
      do_reset();
      req_in = 4'b0001;
      ovr_en = 1'b1;
      for (int c = 5; c <= 7; c++) begin
         ovr_code = 3'(c);
         tick();
         tick();
         checks++; if (svc_valid !== 1'b0) begin failures++; $display("FAIL badcode%0d svc_valid got=%b want=0", c, svc_valid); end
      end
      ovr_en = 1'b0;
      tick();
      checks++; if (svc_valid !== 1'b1 || svc_code !== 3'd1) begin failures++; $display("FAIL badcode_recover valid/code got=%b/%0d want=1/1", svc_valid, svc_code); end
   endtask

   task automatic test_random;
      logic [4:1] s, d, rise, clr, np, novf;
      logic [2:0] code;
      req_in = 4'b0000;
      do_reset();
      for (int k = 0; k <= 8; k++) hist[k] = '0;
      m_p = '0; m_ovf = '0; m_valid = 1'b0; m_code = 0; m_gap = 0;
      for (int n = 0; n < 1500; n++) begin
         for (int b = 1; b <= 4; b++) begin
            if ($urandom_range(0, 5) == 0) req_in[b] = ~req_in[b];
         end
         if ($urandom_range(0, 31) == 0) mask = 4'($urandom_range(0, 15));
         svc_ack = ($urandom_range(0, 2) == 0);
         clr_ovf = ($urandom_range(0, 15) == 0);

         s    = hist[SS-1];
         d    = hist[SS];
         rise = s & ~d;
         clr  = (m_valid && svc_ack) ? (4'b0001 << (m_code - 1)) : 4'b0000;
         code = enc(m_p & ~mask);
         if (EM) begin
            np   = (m_p & ~clr) | (rise & ~mask);
            novf = clr_ovf ? 4'b0000 : (m_ovf | (rise & ~mask & m_p & ~clr));
         end else begin
            np   = s & ~mask & ~clr;
            novf = 4'b0000;
         end
         // Offer/cooldown view of the handshake: one dead cycle after every accept.
         if (m_valid) begin
            if (svc_ack) begin
               m_valid = 1'b0;
               m_gap   = 1;
            end
         end else if (m_gap > 0) begin
            m_gap--;
         end else if (code != 3'd0) begin
            m_valid = 1'b1;
            m_code  = int'(code);
         end
         m_p   = np;
         m_ovf = novf;
         for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = req_in;

         tick();
         checks++; if (r_out !== (m_p & ~mask)) begin failures++; $display("FAIL rand_rout cyc=%0d got=%b want=%b", n, r_out, m_p & ~mask); end
         checks++; if (svc_valid !== m_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", n, svc_valid, m_valid); end
         if (m_valid) begin
            checks++; if (svc_code !== 3'(m_code)) begin failures++; $display("FAIL rand_code cyc=%0d got=%0d want=%0d", n, svc_code, m_code); end
         end
         checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rand_ovf cyc=%0d got=%b want=%b", n, overflow, m_ovf); end
      end
      svc_ack = 1'b0;
      clr_ovf = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_single();
      test_priority();
      test_collision();
      test_overflow_mask();
      test_stability();
      test_bad_code();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
